// File: rtl/ctrl_pkg.sv
// Shared encodings for the ARM-subset control unit: FSM states, opcode and
// command fields, datapath select codes and condition codes.
package ctrl_pkg;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_MEMWAIT,
        S_FAULT
    } state_t;

    // Which flag groups an instruction is allowed to write when S=1.
    typedef enum logic [1:0] {
        FW_NONE,
        FW_NZ,
        FW_NZCV
    } flagw_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] REGSRC_DP  = 2'b00;
    localparam logic [1:0] REGSRC_BR  = 2'b01;
    localparam logic [1:0] REGSRC_STR = 2'b10;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

endpackage

// File: rtl/cond_check.sv
// Condition-code evaluation against the NZCV flags register, plus the
// gated flag-write enables. The flags register itself lives here.
module cond_check
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       s,
    input  flagw_t     flag_w,
    input  logic       exec,
    output logic       cond_ex,
    output logic       nz_we,
    output logic       cv_we
);

    logic [3:0] flags_q, flags_d;
    logic       n, z, c, v;

    always_comb begin
        {n, z, c, v} = flags_q;
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = !z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = !c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = !n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = !v;
            COND_HI: cond_ex = c & !z;
            COND_LS: cond_ex = !c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = !z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        nz_we   = exec & cond_ex & s & (flag_w != FW_NONE);
        cv_we   = exec & cond_ex & s & (flag_w == FW_NZCV);
        flags_d = flags_q;
        if (nz_we) flags_d[3:2] = alu_flags[3:2];
        if (cv_we) flags_d[1:0] = alu_flags[1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) flags_q <= '0;
        else     flags_q <= flags_d;
    end

endmodule

// File: rtl/control_unit.sv
// Instruction decoder and sequencing FSM for the single-cycle ARM-subset
// datapath; loads/stores wait on mem_ready with a timeout into a sticky fault.
module control_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        mem_ready,
    output logic        MemtoReg,
    output logic        ALUSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUControl,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        PCSrc,
    output logic        PCEn,
    output logic        mem_req,
    output logic        Fault
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic       rd_pc;
    logic       dec_valid, is_mem, is_ldr, reg_w, br_op, branch, s_bit;
    flagw_t     flag_w;
    logic       cond_ex, exec, nz_we, cv_we;
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       unused_instr_bits;

    assign op    = Instr[27:26];
    assign funct = Instr[25:20];
    assign cmd   = funct[4:1];
    assign rd_pc = (Instr[15:12] == 4'hF);
    assign unused_instr_bits = &{1'b0, Instr[19:16], Instr[11:0]};

    always_comb begin
        dec_valid  = 1'b0;
        is_mem     = 1'b0;
        is_ldr     = 1'b0;
        reg_w      = 1'b0;
        br_op      = 1'b0;
        s_bit      = 1'b0;
        flag_w     = FW_NONE;
        MemtoReg   = 1'b0;
        ALUSrc     = 1'b0;
        ImmSrc     = IMM_DP;
        RegSrc     = REGSRC_DP;
        ALUControl = ALU_ADD;
        case (op)
            OP_DP: begin
                ALUSrc    = funct[5];
                s_bit     = funct[0];
                dec_valid = 1'b1;
                reg_w     = 1'b1;
                case (cmd)
                    CMD_ADD: begin ALUControl = ALU_ADD; flag_w = FW_NZCV; end
                    CMD_SUB: begin ALUControl = ALU_SUB; flag_w = FW_NZCV; end
                    CMD_AND: begin ALUControl = ALU_AND; flag_w = FW_NZ;   end
                    CMD_ORR: begin ALUControl = ALU_ORR; flag_w = FW_NZ;   end
                    CMD_CMP: begin ALUControl = ALU_SUB; flag_w = FW_NZCV; reg_w = 1'b0; end
                    default: begin dec_valid = 1'b0; reg_w = 1'b0; end
                endcase
            end
            OP_MEM: begin
                dec_valid = 1'b1;
                is_mem    = 1'b1;
                is_ldr    = funct[0];
                ALUSrc    = 1'b1;
                ImmSrc    = IMM_MEM;
                RegSrc    = funct[0] ? REGSRC_DP : REGSRC_STR;
                MemtoReg  = funct[0];
                reg_w     = funct[0];
            end
            OP_BR: begin
                dec_valid = 1'b1;
                br_op     = 1'b1;
                ALUSrc    = 1'b1;
                ImmSrc    = IMM_BR;
                RegSrc    = REGSRC_BR;
            end
            default: dec_valid = 1'b0;
        endcase
        branch = br_op | (reg_w & rd_pc);
    end

    assign exec = (state_q == S_RUN) & dec_valid;

    cond_check u_cond_check (
        .clk      (clk),
        .rst      (rst),
        .cond     (Instr[31:28]),
        .alu_flags(ALUFlags),
        .s        (s_bit),
        .flag_w   (flag_w),
        .exec     (exec),
        .cond_ex  (cond_ex),
        .nz_we    (nz_we),
        .cv_we    (cv_we)
    );

    // Flag enables are consumed inside cond_check; kept visible for debug.
    logic unused_we;
    assign unused_we = nz_we ^ cv_we;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        PCSrc    = 1'b0;
        PCEn     = 1'b0;
        mem_req  = 1'b0;
        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                if (!dec_valid) begin
                    state_d = S_FAULT;
                end else if (is_mem && cond_ex) begin
                    mem_req = 1'b1;
                    cnt_d   = '0;
                    state_d = S_MEMWAIT;
                end else begin
                    PCEn     = 1'b1;
                    RegWrite = reg_w & cond_ex;
                    PCSrc    = branch & cond_ex;
                end
            end
            S_MEMWAIT: begin
                mem_req = 1'b1;
                // A late mem_ready on the final allowed cycle still completes.
                if (mem_ready) begin
                    PCEn     = 1'b1;
                    MemWrite = !is_ldr;
                    RegWrite = is_ldr;
                    PCSrc    = branch;
                    state_d  = S_RUN;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
    end

    assign Fault = (state_q == S_FAULT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_BOOT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/control_unit.md
# control_unit

Sequencing controller for the single-cycle ARM-subset datapath. It decodes the current instruction into the datapath select/enable signals and holds the NZCV condition flags. It gates writes with ARM condition codes and drives the PC write enable. A small FSM stretches loads and stores across a data-memory ready handshake, with a timeout that ends in a sticky fault.

## Interface
- TIMEOUT, 15: maximum MEMWAIT cycles without mem_ready before FAULT (1..255).
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- Instr  in  32  current instruction: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12].
- ALUFlags  in  4  {N,Z,C,V} from the ALU, same cycle.
- mem_ready  in  1  data memory done; sampled only in MEMWAIT.
- MemtoReg, ALUSrc  out  1 each  datapath selects.
- ImmSrc, RegSrc, ALUControl  out  2 each  datapath selects.
- RegWrite, MemWrite, PCSrc  out  1 each  gated write/branch controls.
- PCEn  out  1  PC register write enable.
- mem_req  out  1  data-memory access pending.
- Fault  out  1  sticky fault indicator.

## Operation
- Decode is combinational from Instr and is not gated by state.
- Op=00 (data processing):
  - ALUSrc=Funct[5]; ImmSrc=00; RegSrc=00; MemtoReg=0.
  - ALUControl from Funct[4:1]: 0100 ADD→00; 0010 SUB→01; 0000 AND→10; 1100 ORR→11; 1010 CMP→01 with no register write.
  - Any other cmd is undefined.
  - S=Funct[0] updates NZ. CV is updated only for ADD, SUB and CMP.
- Op=01 (memory): ALUSrc=1; ImmSrc=01; ALUControl=00.
  - L=Funct[0]=1 (LDR): RegSrc=00, MemtoReg=1, register write.
  - L=0 (STR): RegSrc=10, memory write.
- Op=10 (branch): ALUSrc=1; ImmSrc=10; RegSrc=01; ALUControl=00; branch; no register write.
- Op=11: undefined.
- A data-processing instruction or LDR with Rd=15 also counts as a branch (PC write via PCSrc).
- CondEx is computed from Cond and the registered flags:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V.
  - GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 is 0 (no-op).
- Registered flags update only on an executing cycle with CondEx=1 and S=1. Update uses the ALUFlags of that cycle.
- FSM states: BOOT, RUN, MEMWAIT, FAULT.
  - BOOT: all enables 0. Goes to RUN next cycle.
  - RUN, undefined instruction (regardless of Cond): → FAULT, no writes.
  - RUN, memory op with CondEx=1: mem_req=1, PCEn=0, RegWrite=MemWrite=0. → MEMWAIT, counter cleared.
  - RUN, otherwise: PCEn=1. RegWrite, PCSrc and flag update are gated by CondEx. A memory op with CondEx=0 completes here as a no-op.
  - MEMWAIT: mem_req=1. Counter increments each cycle mem_ready=0.
  - MEMWAIT, mem_ready=1: completion cycle. MemWrite=1 (STR) or RegWrite=1 (LDR), plus PCSrc if the instruction is a branch; PCEn=1. → RUN.
  - MEMWAIT, mem_ready=0 with counter==TIMEOUT-1: → FAULT, no writes.
  - FAULT: PCEn, RegWrite, MemWrite, PCSrc, mem_req all 0; Fault=1. Exits only on rst.

## Timing
- Reset values: state=BOOT, flags=0000, counter=0, Fault=0. RegWrite, MemWrite, PCSrc, PCEn, mem_req all 0 while rst is high and asynchronously on assertion.
- Non-memory instruction: 1 cycle. Memory instruction: minimum 2 cycles (RUN + MEMWAIT).
- mem_ready in RUN is ignored.
- mem_ready=1 on the timeout cycle wins: the access completes, no fault.
- Instr must be held stable through MEMWAIT. PCEn=0 guarantees this.
- rst during MEMWAIT: mem_req drops immediately; no write occurs.
- Flag-writing instructions see the new flags from the next instruction onward.

## Structure
- ctrl_pkg holds:
  - state enum;
  - Op codes and cmd codes (ADD/SUB/AND/ORR/CMP);
  - ALUControl codes;
  - ImmSrc/RegSrc codes;
  - condition-code constants.
- Sub-module cond_check: inputs Cond, registered flags, S, FlagW class; outputs CondEx and flag-update enables. The flags register lives in cond_check.
- Decoder and FSM live in control_unit.

## Test plan
- Reset then RUN, Instr=0xE0812002 (ADD R2,R1,R2) → BOOT cycle PCEn=0; next cycle RegWrite=1, ALUControl=00, ALUSrc=0, PCEn=1.
- CMP (0xE1510002) with ALUFlags=0100, then BEQ (0x0A000002) → flags Z=1; branch cycle PCSrc=1. Repeat with ALUFlags=0000 → PCSrc=0, PCEn=1.
- LDR 0xE5912000, mem_ready high on the 3rd MEMWAIT cycle → mem_req high for 4 cycles (RUN + 3 MEMWAIT); RegWrite=1, MemtoReg=1, PCEn=1 only in the last cycle.
- STR with mem_ready held 0, TIMEOUT=15 → Fault=1 after 15 MEMWAIT cycles. MemWrite stays 0; Fault remains set until rst.
- Instr=0xEC000000 (Op=11) → FAULT next cycle, no writes. Then rst asserted mid-cycle → outputs clear immediately, BOOT follows.
- STREQ with Z=0 → single cycle, mem_req=0, MemWrite=0, PCEn=1.
